// File: rtl/argmax_unit.sv
// Argmax over the fc2 scores held in SRAM f: a three-word scan with a 4-lane compare per word.
// Optional build macro ARGMAX_SCORE_EN adds the registered max_score output.
module argmax_unit #(
  parameter int DATA_WIDTH             = 8,
  parameter int DATA_NUM_PER_SRAM_ADDR = 4,
  parameter int CLASS_NUM              = 10
) (
  input  logic                                         clk,
  input  logic                                         srstn,
  input  logic                                         fc2_done,
  output logic [1:0]                                   sram_raddr_f,
  input  logic [DATA_NUM_PER_SRAM_ADDR*DATA_WIDTH-1:0] sram_rdata_f,
  output logic                                         busy,
  output logic                                         class_valid,
  output logic [3:0]                                   class_id
`ifdef ARGMAX_SCORE_EN
  ,
  output logic signed [DATA_WIDTH-1:0]                 max_score
`endif
);

  localparam int         LANES     = DATA_NUM_PER_SRAM_ADDR;
  localparam int         WORD_NUM  = (CLASS_NUM + LANES - 1) / LANES;
  localparam logic [1:0] LAST_WORD = 2'(WORD_NUM - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]                   r_state;
  logic [1:0]                   w_nextState;
  logic [1:0]                   r_rdCnt;
  logic                         r_rdValid;
  logic [1:0]                   r_rdWord;
  logic signed [DATA_WIDTH-1:0] r_runScore;
  logic [3:0]                   r_runIdx;
  logic [3:0]                   r_classId;
  logic                         r_classValid;

  logic signed [DATA_WIDTH-1:0] w_laneScore [LANES];
  logic [3:0]                   w_laneIdx   [LANES];
  logic                         w_laneValid [LANES];
  logic signed [DATA_WIDTH-1:0] w_treeScore;
  logic [3:0]                   w_treeIdx;
  logic                         w_treeValid;
  logic signed [DATA_WIDTH-1:0] w_mergeScore;
  logic [3:0]                   w_mergeIdx;

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE:  if (fc2_done) w_nextState = S_READ;
      S_READ:  if (r_rdCnt == LAST_WORD) w_nextState = S_DRAIN;
      S_DRAIN: w_nextState = S_DONE;
      S_DONE:  w_nextState = S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
  end

  // srstn is active-high despite its name; it wins over everything, including fc2_done.
  always_ff @(posedge clk) begin
    if (srstn) begin
      r_state   <= S_IDLE;
      r_rdCnt   <= 2'd0;
      r_rdValid <= 1'b0;
      r_rdWord  <= 2'd0;
    end else begin
      r_state   <= w_nextState;
      r_rdCnt   <= (r_state == S_READ) ? r_rdCnt + 2'd1 : 2'd0;
      r_rdValid <= (r_state == S_READ);
      r_rdWord  <= r_rdCnt;
    end
  end

  assign sram_raddr_f = (r_state == S_READ) ? r_rdCnt : 2'd0;
  assign busy         = (r_state != S_IDLE);

  // Lane 0 sits in the top bits; lanes past CLASS_NUM are padding and never win.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      w_laneScore[l] = sram_rdata_f[(LANES-1-l)*DATA_WIDTH +: DATA_WIDTH];
      w_laneIdx[l]   = 4'(int'(r_rdWord) * LANES + l);
      w_laneValid[l] = (int'(r_rdWord) * LANES + l) < CLASS_NUM;
    end
  end

  always_comb begin
    w_treeScore = w_laneScore[0];
    w_treeIdx   = w_laneIdx[0];
    w_treeValid = w_laneValid[0];
    for (int l = 1; l < LANES; l++) begin
      if (w_laneValid[l] && (!w_treeValid || (w_laneScore[l] > w_treeScore))) begin
        w_treeScore = w_laneScore[l];
        w_treeIdx   = w_laneIdx[l];
        w_treeValid = 1'b1;
      end
    end
  end

  // Word 0 seeds the running max; later words only replace it on a strictly greater score.
  always_comb begin
    w_mergeScore = r_runScore;
    w_mergeIdx   = r_runIdx;
    if ((r_rdWord == 2'd0) || (w_treeValid && (w_treeScore > r_runScore))) begin
      w_mergeScore = w_treeScore;
      w_mergeIdx   = w_treeIdx;
    end
  end

  always_ff @(posedge clk) begin
    if (srstn) begin
      r_runScore <= '0;
      r_runIdx   <= 4'd0;
    end else if (r_rdValid) begin
      r_runScore <= w_mergeScore;
      r_runIdx   <= w_mergeIdx;
    end
  end

  always_ff @(posedge clk) begin
    if (srstn) begin
      r_classValid <= 1'b0;
      r_classId    <= 4'd0;
    end else begin
      r_classValid <= (r_state == S_DRAIN);
      if (r_state == S_DRAIN) r_classId <= w_mergeIdx;
    end
  end

  assign class_valid = r_classValid;
  assign class_id    = r_classId;

`ifdef ARGMAX_SCORE_EN
  logic signed [DATA_WIDTH-1:0] r_maxScore;

  always_ff @(posedge clk) begin
    if (srstn) r_maxScore <= '0;
    else if (r_state == S_DRAIN) r_maxScore <= w_mergeScore;
  end

  assign max_score = r_maxScore;
`endif

endmodule

// File: tb/tb_argmax_unit.sv
// Self-checking bench for argmax_unit: SRAM f model with one-cycle read latency plus a result scoreboard.
module tb_argmax_unit;

  localparam int DW      = 8;
  localparam int LANES   = 4;
  localparam int CLASSES = 10;

  logic             clk = 1'b0;
  logic             srstn;
  logic             fc2_done;
  logic [1:0]       sram_raddr_f;
  logic [LANES*DW-1:0] sram_rdata_f;
  logic             busy;
  logic             class_valid;
  logic [3:0]       class_id;
`ifdef ARGMAX_SCORE_EN
  logic signed [DW-1:0] max_score;
`endif

  typedef struct {
    int id;
    int score;
  } result_t;

  result_t          expQ[$];
  int               scores[12];
  logic [LANES*DW-1:0] mem[4];
  int               checks = 0;
  int               passes = 0;

  always #5 clk = ~clk;

  argmax_unit #(
    .DATA_WIDTH(DW),
    .DATA_NUM_PER_SRAM_ADDR(LANES),
    .CLASS_NUM(CLASSES)
  ) dut (
    .clk(clk),
    .srstn(srstn),
    .fc2_done(fc2_done),
    .sram_raddr_f(sram_raddr_f),
    .sram_rdata_f(sram_rdata_f),
    .busy(busy),
    .class_valid(class_valid),
    .class_id(class_id)
`ifdef ARGMAX_SCORE_EN
    ,
    .max_score(max_score)
`endif
  );

  // SRAM f: data for the address presented in one cycle appears in the next.
  always @(posedge clk) sram_rdata_f <= mem[sram_raddr_f];

  task automatic loadScores();
    for (int w = 0; w < 3; w++)
      mem[w] = {8'(scores[4*w]), 8'(scores[4*w+1]), 8'(scores[4*w+2]), 8'(scores[4*w+3])};
    mem[3] = '0;
  endtask

  function automatic result_t model();
    result_t r;
    r.id    = 0;
    r.score = scores[0];
    for (int i = 1; i < CLASSES; i++)
      if (scores[i] > r.score) begin
        r.id    = i;
        r.score = scores[i];
      end
    return r;
  endfunction

  function automatic logic busyAt(int c, int s);
    return (c - s >= 1) && (c - s <= 5);
  endfunction

  function automatic logic [1:0] raddrAt(int c, int s);
    if ((c - s >= 1) && (c - s <= 3)) return 2'(c - s - 1);
    return 2'd0;
  endfunction

  task automatic test_reset();
    srstn    = 1'b1;
    fc2_done = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) $display("[TB] FAIL reset busy: got %b want 0", busy); else passes++;
    checks++; if (class_valid !== 1'b0) $display("[TB] FAIL reset class_valid: got %b want 0", class_valid); else passes++;
    checks++; if (class_id !== 4'd0) $display("[TB] FAIL reset class_id: got %0d want 0", class_id); else passes++;
    checks++; if (sram_raddr_f !== 2'd0) $display("[TB] FAIL reset raddr: got %0d want 0", sram_raddr_f); else passes++;
`ifdef ARGMAX_SCORE_EN
    checks++; if (max_score !== 8'sd0) $display("[TB] FAIL reset max_score: got %0d want 0", max_score); else passes++;
`endif
    srstn = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    result_t got;
    scores = '{-3, 5, 12, 7, -128, 0, 12, 1, 2, 3, 0, 0};
    loadScores();
    fc2_done = 1'b1;
    expQ.push_back(model());
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      fc2_done = 1'b0;
      checks++; if (busy !== busyAt(c, 0)) $display("[TB] FAIL basic busy c%0d: got %b want %b", c, busy, busyAt(c, 0)); else passes++;
      checks++; if (sram_raddr_f !== raddrAt(c, 0)) $display("[TB] FAIL basic raddr c%0d: got %0d want %0d", c, sram_raddr_f, raddrAt(c, 0)); else passes++;
      checks++; if (class_valid !== (c == 5)) $display("[TB] FAIL basic class_valid c%0d: got %b want %b", c, class_valid, (c == 5)); else passes++;
      if (class_valid) begin
        checks++;
        if (expQ.size() == 0) $display("[TB] FAIL basic scoreboard c%0d: got valid want none", c);
        else begin
          passes++;
          got = expQ.pop_front();
          checks++; if (class_id !== 4'(got.id)) $display("[TB] FAIL basic class_id: got %0d want %0d", class_id, got.id); else passes++;
`ifdef ARGMAX_SCORE_EN
          checks++; if (int'(max_score) !== got.score) $display("[TB] FAIL basic max_score: got %0d want %0d", max_score, got.score); else passes++;
`endif
        end
      end
      if (c > 5) begin
        checks++; if (class_id !== 4'd2) $display("[TB] FAIL basic hold c%0d: got %0d want 2", c, class_id); else passes++;
      end
    end
  endtask

  task automatic test_boundaries();
    result_t got;
    for (int p = 0; p < 2; p++) begin
      if (p == 0) scores = '{-128, -128, -128, -128, -128, -128, -128, -128, -128, -128, 127, 127};
      else        scores = '{126, 126, 126, 126, 126, 126, 126, 126, 126, 127, 0, 0};
      loadScores();
      fc2_done = 1'b1;
      expQ.push_back(model());
      for (int c = 1; c <= 7; c++) begin
        @(negedge clk);
        fc2_done = 1'b0;
        checks++; if (sram_raddr_f !== raddrAt(c, 0)) $display("[TB] FAIL bound%0d raddr c%0d: got %0d want %0d", p, c, sram_raddr_f, raddrAt(c, 0)); else passes++;
        checks++; if (class_valid !== (c == 5)) $display("[TB] FAIL bound%0d class_valid c%0d: got %b want %b", p, c, class_valid, (c == 5)); else passes++;
        if (class_valid && expQ.size() != 0) begin
          got = expQ.pop_front();
          checks++; if (class_id !== 4'(got.id)) $display("[TB] FAIL bound%0d class_id: got %0d want %0d", p, class_id, got.id); else passes++;
`ifdef ARGMAX_SCORE_EN
          checks++; if (int'(max_score) !== got.score) $display("[TB] FAIL bound%0d max_score: got %0d want %0d", p, max_score, got.score); else passes++;
`endif
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    result_t got;
    int      nValid = 0;
    scores = '{-3, 5, 12, 7, -128, 0, 12, 1, 2, 3, 0, 0};
    loadScores();
    fc2_done = 1'b1;
    expQ.push_back(model());
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      checks++; if (busy !== (busyAt(c, 0) || busyAt(c, 6))) $display("[TB] FAIL b2b busy c%0d: got %b", c, busy); else passes++;
      checks++; if (class_valid !== (c == 5 || c == 11)) $display("[TB] FAIL b2b class_valid c%0d: got %b want %b", c, class_valid, (c == 5 || c == 11)); else passes++;
      if (class_valid) begin
        nValid++;
        checks++;
        if (expQ.size() == 0) $display("[TB] FAIL b2b scoreboard c%0d: got valid want none", c);
        else begin
          passes++;
          got = expQ.pop_front();
          checks++; if (class_id !== 4'(got.id)) $display("[TB] FAIL b2b class_id c%0d: got %0d want %0d", c, class_id, got.id); else passes++;
        end
      end
      fc2_done = (c == 3) || (c == 6);
      if (c == 6) begin
        scores = '{126, 126, 126, 126, 126, 126, 126, 126, 126, 127, 0, 0};
        loadScores();
        expQ.push_back(model());
      end
    end
    fc2_done = 1'b0;
    checks++; if (nValid !== 2) $display("[TB] FAIL b2b valid count: got %0d want 2", nValid); else passes++;
  endtask

  task automatic test_reset_mid();
    result_t got;
    scores = '{-3, 5, 12, 7, -128, 0, 12, 1, 2, 3, 0, 0};
    loadScores();
    fc2_done = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      fc2_done = 1'b0;
      if (c <= 3) begin
        checks++; if (busy !== 1'b1) $display("[TB] FAIL rstmid busy c%0d: got %b want 1", c, busy); else passes++;
      end
      if (c == 4) begin
        checks++; if (busy !== 1'b0) $display("[TB] FAIL rstmid busy after reset: got %b want 0", busy); else passes++;
        checks++; if (class_id !== 4'd0) $display("[TB] FAIL rstmid class_id after reset: got %0d want 0", class_id); else passes++;
      end
      if (c >= 4) begin
        checks++; if (class_valid !== 1'b0) $display("[TB] FAIL rstmid class_valid c%0d: got %b want 0", c, class_valid); else passes++;
      end
      srstn = (c == 3);
    end
    srstn    = 1'b1;
    fc2_done = 1'b1;
    @(negedge clk);
    srstn    = 1'b0;
    fc2_done = 1'b0;
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      checks++; if (busy !== 1'b0) $display("[TB] FAIL priority busy c%0d: got %b want 0", c, busy); else passes++;
    end
    fc2_done = 1'b1;
    expQ.push_back(model());
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      fc2_done = 1'b0;
      checks++; if (class_valid !== (c == 5)) $display("[TB] FAIL fresh class_valid c%0d: got %b want %b", c, class_valid, (c == 5)); else passes++;
      if (class_valid && expQ.size() != 0) begin
        got = expQ.pop_front();
        checks++; if (class_id !== 4'(got.id)) $display("[TB] FAIL fresh class_id: got %0d want %0d", class_id, got.id); else passes++;
      end
    end
  endtask

  initial begin
    srstn    = 1'b1;
    fc2_done = 1'b0;
    for (int w = 0; w < 4; w++) mem[w] = '0;
    test_reset();
    test_basic();
    test_boundaries();
    test_back_to_back();
    test_reset_mid();
    checks++; if (expQ.size() != 0) $display("[TB] FAIL scoreboard leftover: got %0d want 0", expQ.size()); else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/argmax_unit.md
ARGMAX_UNIT -- requirements
Module: argmax_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning signed width of one fc2 score.
REQ-002 SHALL have parameter DATA_NUM_PER_SRAM_ADDR, default 4, meaning scores packed per SRAM f word.
REQ-003 SHALL have parameter CLASS_NUM, default 10, meaning number of valid fc2 scores.
REQ-004 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-005 SHALL have port srstn  input  1  synchronous reset, active-high: asserted = 1, sampled on clk.
REQ-006 SHALL have port fc2_done  input  1  start pulse from FC stage; SRAM f is complete.
REQ-007 SHALL have port sram_raddr_f  output  2  SRAM f read address.
REQ-008 SHALL have port sram_rdata_f  input  DATA_NUM_PER_SRAM_ADDR*DATA_WIDTH  SRAM f read data, valid one cycle after address.
REQ-009 SHALL have port busy  output  1  scan in progress.
REQ-010 SHALL have port class_valid  output  1  one-cycle pulse, class_id updated.
REQ-011 SHALL have port class_id  output  4  index of maximum score, held until the next result.
REQ-012 SHALL have port max_score  output  DATA_WIDTH  signed maximum score; present only with ARGMAX_SCORE_EN.

Function
REQ-013 SHALL implement FSM states IDLE, READ, DRAIN, DONE.
REQ-014 SHALL move IDLE->READ on the cycle after fc2_done is sampled high (call that cycle 0).
REQ-015 SHALL drive sram_raddr_f = 0, 1, 2 in cycles 1, 2, 3 (READ), then hold 0 in all other states.
REQ-016 SHALL treat sram_rdata_f in cycles 2, 3, 4 as words 0, 1, 2 (DRAIN covers cycle 4).
REQ-017 SHALL map class index = 4*word + lane, lane 0 = bits [31:24], lane 3 = bits [7:0].
REQ-018 SHALL ignore lanes giving index >= CLASS_NUM (word 2 lanes 2,3).
REQ-019 SHALL compare as signed two's complement; initial running max = score of index 0.
REQ-020 SHALL resolve ties to the lowest index (strict greater-than replaces).
REQ-021 SHALL process all 4 lanes of a word in one cycle (combinational 4-way tree plus running-max register).
REQ-022 SHALL enter DONE in cycle 5, pulse class_valid=1 for exactly cycle 5, with class_id final in cycle 5, then return to IDLE in cycle 6.
REQ-023 SHALL assert busy in cycles 1-5 inclusive, else 0.
REQ-024 SHALL ignore fc2_done while busy=1; fc2_done in cycle 6 or later starts a new scan.
REQ-025 SHALL keep class_id (and max_score) unchanged outside class_valid cycles.

Reset
REQ-026 SHALL on srstn=1 force state IDLE, sram_raddr_f=0, busy=0, class_valid=0, class_id=0, max_score=0, running max cleared.
REQ-027 SHALL abort any scan when srstn=1 mid-operation, produce no class_valid, and require a fresh fc2_done.
REQ-028 SHALL give srstn priority over a simultaneous fc2_done.

Configuration
REQ-029 SHALL use macro ARGMAX_SCORE_EN: defined -> max_score port exists and is registered with class_id at cycle 5; undefined -> port and its register absent, class_id behaviour identical.

Verification
REQ-030 SHALL cover: scores 0..9 = {-3,5,12,7,-128,0,12,1,2,3}, fc2_done pulse -> class_valid in cycle 5, class_id=2, max_score=12 (tie with 6 resolved low).
REQ-031 SHALL cover: all ten scores = -128, word 2 lanes 2,3 = 127 -> class_id=0, max_score=-128 (unused lanes ignored).
REQ-032 SHALL cover: score 9 = 127, others = 126 -> class_id=9; sram_raddr_f sequence 0,1,2 in cycles 1-3.
REQ-033 SHALL cover: second fc2_done in cycle 3 -> ignored, single class_valid; new fc2_done in cycle 6 -> second class_valid in cycle 11.
REQ-034 SHALL cover: srstn=1 in cycle 3 -> busy=0 and class_id=0 next cycle, no class_valid in cycles 4-10.
REQ-035 SHALL cover: build without ARGMAX_SCORE_EN, REQ-030 stimulus -> class_id=2 at cycle 5, no max_score port.
